// File: rtl/uart_pkg.sv
// uart_pkg: shared UART data width and byte type.
package uart_pkg;
    localparam int UART_DATA_W = 8;
    typedef logic [UART_DATA_W-1:0] uart_byte_t;
endpackage

// File: rtl/uart_sync2.sv
// uart_sync2: two-flop synchroniser with a selectable reset value.
module uart_sync2 #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic s1;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1 <= RST_VAL;
            q  <= RST_VAL;
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end
endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: FWFT byte FIFO fed by the UART receiver's character-ready level.
// UART_RX_FIFO_THRESH_IRQ_EN adds a registered threshold/overrun interrupt.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rx_rdy,
    input  logic [UART_DATA_W-1:0] rx_data,
    input  logic                   rd_en,
    input  logic                   clr_ovr,
    output logic [UART_DATA_W-1:0] rd_data,
    output logic                   empty,
    output logic                   full,
    output logic [AW:0]            count,
    output logic                   overrun
`ifdef UART_RX_FIFO_THRESH_IRQ_EN
    ,
    input  logic [AW:0]            thresh,
    output logic                   irq
`endif
);
    logic s2, s3, push_req, pop, push, ovf, ovr_next;
    logic [AW:0] wr_ptr, rd_ptr, wr_next, rd_next;
    uart_byte_t mem [DEPTH];

    // Synchroniser resets high so a level already up at reset release is not seen as a new character.
    uart_sync2 #(.RST_VAL(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx_rdy),
        .q   (s2)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) s3 <= 1'b1;
        else s3 <= s2;
    end

    assign push_req = s2 & ~s3;
    assign empty    = wr_ptr == rd_ptr;
    assign full     = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign count    = wr_ptr - rd_ptr;
    assign rd_data  = empty ? '0 : mem[rd_ptr[AW-1:0]];
    assign pop      = rd_en & ~empty;
    assign push     = push_req & (~full | pop);
    assign ovf      = push_req & full & ~pop;
    assign wr_next  = wr_ptr + {{AW{1'b0}}, push};
    assign rd_next  = rd_ptr + {{AW{1'b0}}, pop};
    assign ovr_next = ovf | (overrun & ~clr_ovr);

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= rx_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            overrun <= 1'b0;
        end else begin
            wr_ptr  <= wr_next;
            rd_ptr  <= rd_next;
            overrun <= ovr_next;
        end
    end

`ifdef UART_RX_FIFO_THRESH_IRQ_EN
    logic [AW:0] count_next;
    assign count_next = wr_next - rd_next;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) irq <= 1'b0;
        else irq <= (count_next >= thresh) | ovr_next;
    end
`endif
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: random and directed traffic checked against a queue model of the receive FIFO.
module tb_uart_rx_fifo;
    localparam int DEPTH = 16;
    localparam int AW = $clog2(DEPTH);

    logic clk = 1'b0, rst = 1'b0, rx_rdy = 1'b1, rd_en = 1'b0, clr_ovr = 1'b0;
    logic [7:0] rx_data = 8'h00, rd_data;
    logic empty, full, overrun;
    logic [AW:0] count;
`ifdef UART_RX_FIFO_THRESH_IRQ_EN
    logic [AW:0] thresh = 5'(4);
    logic irq;
    bit m_irq = 1'b0;
`endif

    int checks = 0, errors = 0;
    logic [7:0] q[$];
    bit hist[$];
    bit m_ovr = 1'b0;

    always #5 clk = ~clk;

    uart_rx_fifo #(.DEPTH(DEPTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .rx_rdy  (rx_rdy),
        .rx_data (rx_data),
        .rd_en   (rd_en),
        .clr_ovr (clr_ovr),
        .rd_data (rd_data),
        .empty   (empty),
        .full    (full),
        .count   (count),
        .overrun (overrun)
`ifdef UART_RX_FIFO_THRESH_IRQ_EN
        ,
        .thresh  (thresh),
        .irq     (irq)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Level history before reset release counts as high, so no character is seen at start-up.
    function automatic bit rdy_at(int i);
        return i < 0 ? 1'b1 : hist[i];
    endfunction

    task automatic compare_all();
        check("empty", 32'(empty), 32'(q.size() == 0));
        check("full", 32'(full), 32'(q.size() == DEPTH));
        check("count", 32'(count), 32'(q.size()));
        check("rd_data", 32'(rd_data), 32'(q.size() != 0 ? q[0] : 8'h00));
        check("overrun", 32'(overrun), 32'(m_ovr));
`ifdef UART_RX_FIFO_THRESH_IRQ_EN
        check("irq", 32'(irq), 32'(m_irq));
`endif
    endtask

    // One clock: inputs applied after a falling edge, model advanced at the rising edge, outputs checked 1 time unit later.
    task automatic step(input bit rdy, input logic [7:0] d, input bit rd, input bit clr);
        int n;
        bit new_char, do_pop, drop;
        rx_rdy = rdy;
        rx_data = d;
        rd_en = rd;
        clr_ovr = clr;
        @(posedge clk);
        n = hist.size();
        new_char = rdy_at(n - 2) && !rdy_at(n - 3);
        do_pop = rd_en && q.size() > 0;
        drop = new_char && q.size() == DEPTH && !do_pop;
        hist.push_back(rx_rdy);
        if (do_pop) void'(q.pop_front());
        if (new_char && !drop) q.push_back(rx_data);
        m_ovr = drop ? 1'b1 : (clr_ovr ? 1'b0 : m_ovr);
`ifdef UART_RX_FIFO_THRESH_IRQ_EN
        m_irq = (q.size() >= int'(thresh)) || m_ovr;
`endif
        #1 compare_all();
        @(negedge clk);
    endtask

    // A character: low, then high long enough to be seen; rd can coincide with the push cycle.
    task automatic send_byte(input logic [7:0] b, input bit rd_at_push);
        step(1'b0, b, 1'b0, 1'b0);
        step(1'b1, b, 1'b0, 1'b0);
        step(1'b1, b, 1'b0, 1'b0);
        step(1'b1, b, rd_at_push, 1'b0);
        step(1'b0, b, 1'b0, 1'b0);
    endtask

    task automatic drain();
        while (q.size() > 0) step(1'b0, 8'($urandom), 1'b1, 1'b0);
    endtask

    initial begin
        #1 compare_all();
        repeat (3) @(negedge clk);
        compare_all();
        rst = 1'b1;
        repeat (10) step(1'b1, 8'($urandom), 1'b0, 1'b0);

        send_byte(8'hA5, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);

        for (int i = 0; i < 16; i++) send_byte(8'(i), 1'b0);
        send_byte(8'hFF, 1'b0);
        drain();
        step(1'b0, 8'h00, 1'b0, 1'b1);

        for (int i = 0; i < 16; i++) send_byte(8'($urandom), 1'b0);
        send_byte(8'h5A, 1'b1);
        drain();

        send_byte(8'h00, 1'b0);
        for (int i = 1; i < 40; i++) send_byte(8'(i), 1'b1);
        drain();
        repeat (3) step(1'b0, 8'h00, 1'b1, 1'b0);

`ifdef UART_RX_FIFO_THRESH_IRQ_EN
        for (int i = 0; i < 4; i++) send_byte(8'($urandom), 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        drain();
`endif

        for (int r = 0; r < 120; r++) begin
            bit rd_bias = r < 60;
            int hi = $urandom_range(3, 5), lo = $urandom_range(1, 4);
            logic [7:0] b = 8'($urandom);
`ifdef UART_RX_FIFO_THRESH_IRQ_EN
            if ($urandom_range(0, 15) == 0) thresh = 5'($urandom_range(0, DEPTH));
`endif
            for (int k = 0; k < hi; k++)
                step(1'b1, b, rd_bias ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 9) < 4),
                     $urandom_range(0, 9) == 0);
            for (int k = 0; k < lo; k++)
                step(1'b0, 8'($urandom), $urandom_range(0, 9) < 4, $urandom_range(0, 9) == 0);
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Receive-side buffer directly downstream of the UART core. Detects each new-character indication from the receiver and captures the received byte into a DEPTH-entry FIFO. The CPU-side register/bus logic reads the bytes out at its own pace. Decouples the baud-clocked receiver from software latency and reports overrun when bytes are lost.

Parameters:
DEPTH, 16, FIFO entries; power of two, >= 2
AW, $clog2(DEPTH), pointer index width (derived; not overridden)

Ports:
clk  in  1  system clock, rising-edge
rst  in  1  asynchronous, active-low reset
rx_rdy  in  1  receiver "character ready" level (USR[1]); asynchronous to clk (baud domain)
rx_data  in  8  received byte (UDRR); stable while rx_rdy is high
rd_en  in  1  pop request from bus side
clr_ovr  in  1  clears the overrun flag
rd_data  out  8  head-of-FIFO byte (first-word fall-through)
empty  out  1  FIFO holds no bytes
full  out  1  FIFO holds DEPTH bytes
count  out  AW+1  number of stored bytes, 0..DEPTH
overrun  out  1  sticky: a byte was dropped because the FIFO was full

Behaviour:
- Reset, async on rst low: wr_ptr=rd_ptr=0, count=0, empty=1, full=0, overrun=0, rd_data=0.
- Synchroniser flops s1, s2 and edge-history flop s3 reset to 1. A rx_rdy already high at reset release therefore does not push a stale byte.
- Synchroniser: s1<=rx_rdy, s2<=s1, s3<=s2. push_req = s2 & ~s3 (rising edge, one clk pulse per character).
- rx_data is sampled in the same cycle push_req is high. It is written at the next clk edge.
- Latency: rx_rdy rise to empty=0 is 3 clk edges.
- Pointers are AW+1 bits with free-running wrap. Memory index = ptr[AW-1:0].
  - empty = (wr_ptr==rd_ptr).
  - full = index bits equal and MSBs differ.
  - count = wr_ptr - rd_ptr, modulo 2^(AW+1).
- rd_data always reflects mem[rd_ptr] (combinational read of the registered array, FWFT). When empty=1, rd_data is 0.
- pop = rd_en & ~empty. rd_en while empty is ignored: no pointer change, no error.
- push = push_req & (~full | pop).
- Push and pop in the same cycle:
  - Both take effect and count is unchanged.
  - When full, a simultaneous pop frees a slot, so the push succeeds and no overrun is flagged.
  - When empty, a simultaneous pop is ignored (pop gated by empty). The push lands, and rd_data shows the byte one cycle later.
- Overflow: push_req & full & ~pop → byte discarded, pointers unchanged, overrun<=1.
- overrun clears on clr_ovr. If a set and clr_ovr occur in the same cycle, set wins.
- No other state machine. Control is pointer/flag logic only. Outputs full, empty and count are registered-pointer derived (glitch-free).

Optional Feature:
UART_RX_FIFO_THRESH_IRQ_EN
- Defined: adds input thresh [AW:0] and output irq 1.
  - irq is registered, reset 0.
  - irq <= (count_next >= thresh) | overrun_next, where count_next and overrun_next are the post-update values. irq therefore asserts in the same cycle count/overrun show the new value.
  - thresh=0 forces irq=1 out of reset+1.
- Undefined: ports thresh and irq do not exist, and no threshold logic is synthesised.

Decomposition:
- Shared package uart_pkg: UART_DATA_W=8; typedef uart_byte_t.
- One sub-module, uart_sync2: 2-flop synchroniser with a reset-value parameter, reusable for rx/tx line sync elsewhere.
- FIFO storage and pointer logic stay in uart_rx_fifo.

Test Plan:
1. Reset release with rx_rdy held high → no push; empty=1, count=0 for 10 cycles.
2. Push 0xA5, i.e. rx_rdy rising with rx_data=0xA5 → empty=0 exactly 3 clk edges later; rd_data=0xA5, count=1. Then rd_en for 1 cycle → empty=1, count=0.
3. Push 16 bytes 0x00..0x0F with no reads → full=1, count=16. A 17th byte 0xFF → dropped, overrun=1, count=16. Draining yields 0x00..0x0F in order. clr_ovr → overrun=0.
4. When full, a 17th push coincident with rd_en → count stays 16, overrun=0. The last byte read after drain is the new byte.
5. Pointer wrap: 40 push/pop pairs of incrementing bytes, interleaved → data is in order, count never exceeds 2, no overrun. Separately, rd_en while empty → count stays 0.
6. With UART_RX_FIFO_THRESH_IRQ_EN and thresh=4 → irq=0 after 3 pushes, irq=1 after the 4th. A single pop drops irq the cycle count becomes 3. An overflow forces irq=1 regardless of count.
